// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 fetch types and constants
package legv8_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 16;

    // BR XZR: also the ROM's default fill, so running off the program halts fetch.
    localparam logic [INST_W-1:0] HALT_WORD_DEF = 32'hD60003E0;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t pc;
        inst_t data;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction FIFO with flush and registered head entry
module fetch_fifo
    import legv8_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         head_valid,
    output fetch_entry_t head_entry,
    output logic         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign full       = (count == CNT_MAX);
    assign do_pop     = pop && head_valid;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push    = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head_entry = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - LEGv8 instruction fetch: PC, halt detection, redirect, decode FIFO
module fetch_ctrl
    import legv8_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [15:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    addr_t        pc;
    addr_t        pc_nxt;
    logic         pop;
    logic         fetch;
    logic         fifo_full;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign pop   = inst_valid && inst_ready;
    assign fetch = (state == ST_RUN) && !redirect_valid && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // The halt word is enqueued but the PC stays on it, so rom_addr keeps pointing at the halt.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (redirect_valid) begin
            state_nxt = ST_RUN;
            pc_nxt    = redirect_pc;
        end else if (fetch) begin
            if (rom_data == HALT_WORD) begin
                state_nxt = ST_HALT;
            end else begin
                pc_nxt = pc + 16'd1;
            end
        end
    end

    assign push_entry = '{pc: pc, data: rom_data};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (fetch),
        .push_entry (push_entry),
        .pop        (pop && !redirect_valid),
        .head_valid (inst_valid),
        .head_entry (head_entry),
        .full       (fifo_full)
    );

    assign rom_addr  = pc;
    assign inst_data = head_entry.data;
    assign inst_pc   = head_entry.pc;
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [31:0] HALT = 32'hD60003E0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic        halt_en;

    int tests = 0;
    int fails = 0;
    logic [47:0] exp_q [$];

    always #5 clk = ~clk;

    assign rom_data = (halt_en && rom_addr == 16'd10) ? HALT : {16'hC0DE, rom_addr};

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_q.push_back({pc, 16'hC0DE, pc});
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_redirect(input logic [15:0] target, input logic ready);
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        inst_ready     = ready;
        step(1);
        redirect_valid = 1'b0;
    endtask

    // Monitor: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery_pc", {16'h0, inst_pc}, 32'hFFFF_FFFF);
            end else begin
                check("sb_pc", {16'h0, inst_pc}, {16'h0, exp_q[0][47:32]});
                check("sb_data", inst_data, exp_q[0][31:0]);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        halt_en        = 1'b0;
        step(2);
        check("reset_rom_addr", {16'h0, rom_addr}, 32'h0);
        check("reset_valid", {31'h0, inst_valid}, 32'h0);
        check("reset_data", inst_data, 32'h0);
        check("reset_pc", {16'h0, inst_pc}, 32'h0);
        check("reset_halted", {31'h0, halted}, 32'h0);

        // Stream
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        for (int p = 0; p < 5; p++) push_exp(16'(p));
        step(6);
        inst_ready = 1'b0;
        check("stream_drained", exp_q.size(), 32'd0);

        // Backpressure from PC 0
        do_redirect(16'h0000, 1'b0);
        check("redir_valid_low", {31'h0, inst_valid}, 32'h0);
        for (int p = 0; p < 4; p++) push_exp(16'(p));
        step(5);
        check("bp_rom_addr", {16'h0, rom_addr}, 32'd2);
        check("bp_head_pc", {16'h0, inst_pc}, 32'd0);
        check("bp_valid", {31'h0, inst_valid}, 32'h1);
        inst_ready = 1'b1;
        step(4);
        check("bp_drained", exp_q.size(), 32'd0);

        // Fill to 8,9 then redirect to 3 coinciding with a pop
        do_redirect(16'h0008, 1'b0);
        step(3);
        check("full_head_pc", {16'h0, inst_pc}, 32'd8);
        check("full_rom_addr", {16'h0, rom_addr}, 32'd10);
        do_redirect(16'h0003, 1'b1);
        check("redir_flush_valid", {31'h0, inst_valid}, 32'h0);
        push_exp(16'h0003);
        step(1);
        check("redir_first_pc", {16'h0, inst_pc}, 32'd3);
        step(1);
        check("redir_drained", exp_q.size(), 32'd0);

        // Halt at address 10
        halt_en = 1'b1;
        do_redirect(16'h0000, 1'b1);
        for (int p = 0; p < 10; p++) push_exp(16'(p));
        exp_q.push_back({16'd10, HALT});
        step(11);
        check("halt_halted", {31'h0, halted}, 32'h1);
        step(3);
        check("halt_rom_addr", {16'h0, rom_addr}, 32'd10);
        check("halt_no_push", {31'h0, inst_valid}, 32'h0);
        check("halt_drained", exp_q.size(), 32'd0);
        check("halt_held", {31'h0, halted}, 32'h1);

        // Leave halt by redirect to 0
        do_redirect(16'h0000, 1'b0);
        check("unhalt", {31'h0, halted}, 32'h0);
        step(1);
        check("resume_valid", {31'h0, inst_valid}, 32'h1);
        check("resume_pc", {16'h0, inst_pc}, 32'd0);
        check("resume_data", inst_data, 32'hC0DE_0000);

        // Wrap
        halt_en = 1'b0;
        do_redirect(16'hFFFF, 1'b1);
        push_exp(16'hFFFF);
        push_exp(16'h0000);
        step(3);
        inst_ready = 1'b0;
        check("wrap_drained", exp_q.size(), 32'd0);
        step(2);
        check("wrap_rom_addr", {16'h0, rom_addr}, 32'd3);

        // Asynchronous reset with a full FIFO
        check("prereset_valid", {31'h0, inst_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {31'h0, inst_valid}, 32'h0);
        check("areset_pc", {16'h0, inst_pc}, 32'h0);
        check("areset_data", inst_data, 32'h0);
        check("areset_rom_addr", {16'h0, rom_addr}, 32'h0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        push_exp(16'h0000);
        step(1);
        check("restart_pc", {16'h0, inst_pc}, 32'd0);
        step(1);
        inst_ready = 1'b0;
        check("restart_drained", exp_q.size(), 32'd0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller for the single-cycle/pipelined LEGv8 core. Owns the program counter, drives the word address of the combinational instruction ROM, and buffers fetched words in a small FIFO toward decode with a valid/ready handshake. Accepts branch redirects from execute and stops fetching when it fetches the halt word (`BR XZR`, the ROM's default contents).

## Interface
Parameters:
- `DEPTH`, 2: instruction FIFO entries (power of two, ≥2).
- `RESET_PC`, 16'h0000: word address fetched first after reset.
- `HALT_WORD`, 32'hD60003E0: encoding that halts fetch (`BR XZR`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rom_addr`  out  16  ROM word address, equal to PC.
- `rom_data`  in  32  ROM output for `rom_addr`, valid in the same cycle (combinational ROM).
- `inst_valid`  out  1  FIFO head holds an instruction.
- `inst_data`  out  32  instruction at FIFO head.
- `inst_pc`  out  16  word address of `inst_data`.
- `inst_ready`  in  1  decode accepts head this cycle.
- `redirect_valid`  in  1  branch taken; flush and restart.
- `redirect_pc`  in  16  new word address.
- `halted`  out  1  fetch stopped on `HALT_WORD`.

## Operation
- States: `RUN`, `HALT`. Reset enters `RUN` with PC=`RESET_PC`, FIFO empty.
- pop = `inst_valid && inst_ready`.
- fetch = `RUN && !redirect_valid && (count < DEPTH || pop)`. On fetch: push {PC, `rom_data`}; PC ← PC+1 (16-bit, wraps 16'hFFFF→16'h0000).
- If pushed word equals `HALT_WORD`: it is still enqueued, PC is not incremented, state → `HALT`. In `HALT` no pushes; pops continue draining.
- Redirect (highest priority, any state): FIFO flushed (count←0, pointers reset), any same-cycle pop or push discarded, PC ← `redirect_pc`, state → `RUN`.
- `rom_addr` = PC at all times, including `HALT` (holds the halt word's address).
- FIFO outputs are registered head entry; contents of empty entries are don't-care, but `inst_data`/`inst_pc` read as 0 when empty.
- Simultaneous push and pop when full: allowed, count unchanged.

## Timing
- Reset values: `rom_addr`=`RESET_PC`, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `halted`=0.
- Fetch-to-valid latency: 1 cycle (word pushed at edge N is at head after edge N if FIFO was empty).
- With `inst_ready` held 1 and no redirects: one instruction per cycle, consecutive PCs.
- Redirect at edge N: `inst_valid`=0 after edge N; first redirected instruction valid after edge N+1.
- `halted` rises the cycle after the halt word is pushed; falls the cycle after a redirect.
- Reset asserted mid-stream: all state cleared immediately (asynchronous); first fetch at first edge after `rst_n` rises.

## Structure
- Shared package `legv8_pkg`: `INST_W`=32, `ADDR_W`=16, `HALT_WORD` constant, instruction typedef `inst_t`, fetch state enum.
- Sub-module `fetch_fifo` (synchronous FIFO with flush, count, registered head); `fetch_ctrl` holds PC, state machine, push/pop/flush logic.

## Test plan
- Stream: ROM returns addr-encoded words, `inst_ready`=1 → `inst_pc` = 0,1,2,… one per cycle from cycle 1, `inst_data` matches.
- Backpressure: `inst_ready`=0 for 5 cycles from PC 0 → count saturates at 2, `rom_addr` holds at 2; release → PCs 0,1,2,3 in order, none lost or duplicated.
- Redirect with full FIFO: `redirect_pc`=16'h0003 → next cycle `inst_valid`=0, following cycle `inst_pc`=3; stale entries never delivered; redirect coinciding with pop drops the pop.
- Halt: `HALT_WORD` at address 10 → entries 0–10 delivered, `halted`=1, `rom_addr` stays 10, no further pushes; redirect to 0 → `halted`=0, fetch resumes at 0.
- Wrap: `redirect_pc`=16'hFFFF → delivered PCs 16'hFFFF then 16'h0000.
- Reset mid-operation: `rst_n` low asynchronously with FIFO full → outputs at reset values without a clock edge; restart fetches `RESET_PC`.
